// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   UART_OVERSAMPLE_DEF - default sample_tick pulses per bit period
//   UART_DATA_WIDTH_DEF - default data bits per frame
//   rx_state_e          - receiver FSM state encoding
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE_DEF = 16;
    localparam int unsigned UART_DATA_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-side handshake of the UART receiver.
//   rx_data    - received byte, stable while rx_valid is high
//   rx_valid   - rx_data holds an unconsumed byte
//   rx_ready   - consumer accepts rx_data when rx_valid & rx_ready
//   frame_err  - one-cycle pulse, stop bit sampled low
//   overrun    - one-cycle pulse, frame completed while the held byte was not accepted
//   parity_err - one-cycle pulse, parity mismatch (always 0 without parity support)
// Modports: master = receiver side, slave = byte consumer side.
interface uart_rx_if #(
    parameter int unsigned DATA_WIDTH = uart_pkg::UART_DATA_WIDTH_DEF
) ();

    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  frame_err;
    logic                  overrun;
    logic                  parity_err;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  parity_err,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_sipo.sv
// uart_rx_sipo: serial-in parallel-out shift register (the receiver's sipo).
// Each shift_en_i loads serial_in_i into the MSB and shifts right, so a stream sent
// LSB-first ends up in natural bit order after WIDTH shifts.
//   clk         - system clock
//   rst_n       - asynchronous active-low reset, clears the register
//   shift_en_i  - shift strobe
//   serial_in_i - serial data bit
//   data_o      - parallel contents
module uart_rx_sipo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en_i,
    input  logic             serial_in_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (shift_en_i) begin
            data_d = {serial_in_i, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receive path. Synchronizes rxd, qualifies the start bit at mid-bit,
// shifts DATA_WIDTH bits in LSB-first, checks the stop bit and presents each byte on a
// valid/ready output register with framing and overrun pulses.
// Optional feature: define UART_RX_PARITY_EN for one even-parity bit after the data.
//   clk         - system clock, all logic on posedge
//   rst_n       - asynchronous active-low reset
//   sample_tick - one-cycle strobe at OVERSAMPLE x baud
//   rxd         - asynchronous serial input, idle high
//   rx_if       - byte-side handshake (master modport)
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH_DEF,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_tick,
    input  logic       rxd,
    uart_rx_if.master  rx_if
);

    localparam int unsigned TickCntW = $clog2(OVERSAMPLE);
    localparam int unsigned BitCntW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TickCntW-1:0] TickHalf = TickCntW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickCntW-1:0] TickLast = TickCntW'(OVERSAMPLE - 1);
    localparam logic [BitCntW-1:0]  BitLast  = BitCntW'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [TickCntW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
    logic                  rxd_meta_q, rxd_sync_q;
    logic                  rxd_prev_q, rxd_prev_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  shift_en;
    logic                  deliver;
    logic [DATA_WIDTH-1:0] sipo_data;
`ifdef UART_RX_PARITY_EN
    logic                  parity_bad_q, parity_bad_d;
    logic                  parity_err_q, parity_err_d;
`endif

    uart_rx_sipo #(
        .WIDTH (DATA_WIDTH)
    ) u_sipo (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_en_i  (shift_en),
        .serial_in_i (rxd_sync_q),
        .data_o      (sipo_data)
    );

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        shift_en    = 1'b0;
        deliver     = 1'b0;
        // Edge history only moves on ticks so a start edge between ticks is not lost.
        rxd_prev_d  = sample_tick ? rxd_sync_q : rxd_prev_q;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
        parity_err_d = 1'b0;
`endif

        if (rx_valid_q && rx_if.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (sample_tick) begin
            case (state_q)
                StIdle: begin
                    // Falling edge only: a stuck-low line cannot retrigger.
                    if (rxd_prev_q && !rxd_sync_q) begin
                        state_d    = StStart;
                        tick_cnt_d = '0;
                    end
                end
                StStart: begin
                    if (tick_cnt_q == TickHalf) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rxd_sync_q ? StIdle : StData;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (tick_cnt_q == TickLast) begin
                        shift_en   = 1'b1;
                        tick_cnt_d = '0;
                        if (bit_cnt_q == BitLast) begin
                            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d   = StParity;
`else
                            state_d   = StStop;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (tick_cnt_q == TickLast) begin
                        // Even parity: data plus parity bit must have an even count of ones.
                        parity_bad_d = ^{sipo_data, rxd_sync_q};
                        tick_cnt_d   = '0;
                        state_d      = StStop;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        state_d    = StIdle;
                        if (!rxd_sync_q) begin
                            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_bad_q) begin
                            parity_err_d = 1'b1;
`endif
                        end else begin
                            deliver = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = StIdle;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            endcase
        end

        if (deliver) begin
            if (!rx_valid_q || rx_if.rx_ready) begin
                rx_data_d  = sipo_data;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            rxd_meta_q  <= 1'b1;
            rxd_sync_q  <= 1'b1;
            rxd_prev_q  <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            rxd_meta_q  <= rxd;
            rxd_sync_q  <= rxd_meta_q;
            rxd_prev_q  <= rxd_prev_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_bad_q <= parity_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign rx_if.parity_err = parity_err_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with OVERSAMPLE=16, DATA_WIDTH=8 and
// sample_tick held high, so one bit period is 16 clocks.
module tb_uart_rx;
    import uart_pkg::*;

`ifdef UART_RX_PARITY_EN
    localparam int FrameBits = 11;
`else
    localparam int FrameBits = 10;
`endif
    // Negedges from start-bit drive to the cycle whose posedge samples the stop bit:
    // 2 sync flops + 1 edge register + 8 half-bit ticks, then 16 per remaining bit.
    localparam int ReadyDelay = FrameBits * 16 - 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sample_tick = 1'b1;
    logic rxd = 1'b1;

    int n_checks = 0;
    int n_fail = 0;
    int valid_rises = 0;
    int frame_err_cnt = 0;
    int overrun_cnt = 0;
    int parity_err_cnt = 0;
    logic [7:0] rise_data = 8'h00;
    logic prev_valid = 1'b0;

    uart_rx_if #(.DATA_WIDTH(8)) rx_if ();

    uart_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .rxd         (rxd),
        .rx_if       (rx_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_if.rx_valid && !prev_valid) begin
            valid_rises++;
            rise_data = rx_if.rx_data;
        end
        prev_valid = rx_if.rx_valid;
        if (rx_if.frame_err)  frame_err_cnt++;
        if (rx_if.overrun)    overrun_cnt++;
        if (rx_if.parity_err) parity_err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit);
        rxd = 1'b0;
        idle(16);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            idle(16);
        end
`ifdef UART_RX_PARITY_EN
        rxd = par_bit;
        idle(16);
`else
        if (par_bit === 1'bx) rxd = 1'b1;
`endif
        rxd = stop_bit;
        idle(16);
        rxd = 1'b1;
    endtask

    initial begin
        rx_if.rx_ready = 1'b1;
        idle(3);
        // Reset state
        check("reset_valid", 32'(rx_if.rx_valid), 32'h0);
        check("reset_data", 32'(rx_if.rx_data), 32'h0);
        check("reset_frame_err", 32'(rx_if.frame_err), 32'h0);
        check("reset_overrun", 32'(rx_if.overrun), 32'h0);
        check("reset_parity_err", 32'(rx_if.parity_err), 32'h0);
        check("reset_state", 32'(dut.state_q), 32'(StIdle));
        rst_n = 1'b1;
        idle(5);

        // 1: good frame 0xA5, consumed immediately
        send_frame(8'hA5, 1'b1, ^8'hA5);
        idle(20);
        check("t1_rises", 32'(valid_rises), 32'd1);
        check("t1_data", 32'(rise_data), 32'hA5);
        check("t1_valid_consumed", 32'(rx_if.rx_valid), 32'h0);
        check("t1_frame_err", 32'(frame_err_cnt), 32'd0);
        check("t1_overrun", 32'(overrun_cnt), 32'd0);

        // 2: 4-tick low glitch is rejected
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(30);
        check("t2_rises", 32'(valid_rises), 32'd1);
        check("t2_state", 32'(dut.state_q), 32'(StIdle));
        check("t2_frame_err", 32'(frame_err_cnt), 32'd0);

        // 3: bad stop bit, then a good frame
        send_frame(8'h3C, 1'b0, ^8'h3C);
        idle(20);
        check("t3_frame_err", 32'(frame_err_cnt), 32'd1);
        check("t3_no_valid", 32'(valid_rises), 32'd1);
        send_frame(8'h01, 1'b1, ^8'h01);
        idle(20);
        check("t3_rises", 32'(valid_rises), 32'd2);
        check("t3_data", 32'(rise_data), 32'h01);

        // 4: overrun while the held byte is not accepted
        rx_if.rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, ^8'h11);
        send_frame(8'h22, 1'b1, ^8'h22);
        idle(10);
        check("t4_valid", 32'(rx_if.rx_valid), 32'h1);
        check("t4_data_held", 32'(rx_if.rx_data), 32'h11);
        check("t4_overrun", 32'(overrun_cnt), 32'd1);
        check("t4_rises", 32'(valid_rises), 32'd3);
        rx_if.rx_ready = 1'b1;
        idle(1);
        rx_if.rx_ready = 1'b0;
        check("t4_consumed", 32'(rx_if.rx_valid), 32'h0);

        // 5: ready rises in the same cycle the next byte completes
        send_frame(8'h11, 1'b1, ^8'h11);
        idle(10);
        check("t5_first_data", 32'(rx_if.rx_data), 32'h11);
        check("t5_rises", 32'(valid_rises), 32'd4);
        fork
            send_frame(8'h22, 1'b1, ^8'h22);
            begin
                idle(ReadyDelay);
                rx_if.rx_ready = 1'b1;
                idle(1);
                rx_if.rx_ready = 1'b0;
            end
        join
        idle(5);
        check("t5_valid", 32'(rx_if.rx_valid), 32'h1);
        check("t5_data", 32'(rx_if.rx_data), 32'h22);
        check("t5_no_overrun", 32'(overrun_cnt), 32'd1);

        // 6: reset mid-DATA clears the held byte and aborts the frame
        rxd = 1'b0;
        idle(16);
        rxd = 1'b1;
        idle(40);
        rst_n = 1'b0;
        idle(2);
        check("t6_valid", 32'(rx_if.rx_valid), 32'h0);
        check("t6_data", 32'(rx_if.rx_data), 32'h0);
        check("t6_state", 32'(dut.state_q), 32'(StIdle));
        rst_n = 1'b1;
        rx_if.rx_ready = 1'b1;
        idle(20);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        idle(20);
        check("t6_rises", 32'(valid_rises), 32'd5);
        check("t6_after_data", 32'(rise_data), 32'h5A);
        check("t6_frame_err", 32'(frame_err_cnt), 32'd1);
`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        idle(20);
        check("t6_parity_err", 32'(parity_err_cnt), 32'd1);
        check("t6_parity_drop", 32'(valid_rises), 32'd5);
`else
        check("t6_parity_tied", 32'(parity_err_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
